// File: rtl/tmc_timer_master.sv
// Avalon-MM initiator for the 16-bit interval timer: programs/starts the timer,
// takes 32-bit counter snapshots and services the timer interrupt.
module tmc_timer_master (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_start,
   input  logic [31:0] cmd_period,
   input  logic        cmd_continuous,
   input  logic        cmd_irq_en,
   input  logic        snap_req,
   output logic        busy,
   output logic        snap_valid,
   output logic [31:0] snap_value,
   output logic        timeout_pulse,
   output logic [15:0] timeout_count,
   output logic [2:0]  av_address,
   output logic        av_chipselect,
   output logic        av_write_n,
   output logic [15:0] av_writedata,
   input  logic [15:0] av_readdata,
   input  logic        irq_in
);

   typedef enum logic [3:0] {
      S_IDLE, S_PL, S_PH, S_CTRL, S_SNAP_W, S_RD_L, S_RD_H, S_CAP, S_CLR
   } state_t;

   localparam logic [2:0] A_STATUS = 3'd0;
   localparam logic [2:0] A_CTRL   = 3'd1;
   localparam logic [2:0] A_PER_L  = 3'd2;
   localparam logic [2:0] A_PER_H  = 3'd3;
   localparam logic [2:0] A_SNAP_L = 3'd4;
   localparam logic [2:0] A_SNAP_H = 3'd5;

   state_t      state, state_nxt;
   logic        start_pend, snap_pend;
   logic [31:0] pend_period, work_period;
   logic        pend_cont, pend_ito, work_cont, work_ito;
   logic [15:0] snap_lo;
   logic        take_start, take_snap;

   logic        bus_cs, bus_wn;
   logic [2:0]  bus_addr;
   logic [15:0] bus_data;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign busy = (state != S_IDLE) || start_pend || snap_pend;

   always_comb begin
      state_nxt  = state;
      take_start = 1'b0;
      take_snap  = 1'b0;
      case (state)
         S_IDLE: begin
            if (irq_in) begin
               state_nxt = S_CLR;
            end else if (start_pend) begin
               state_nxt  = S_PL;
               take_start = 1'b1;
            end else if (snap_pend) begin
               state_nxt = S_SNAP_W;
               take_snap = 1'b1;
            end
         end
         S_PL:     state_nxt = S_PH;
         S_PH:     state_nxt = S_CTRL;
         S_CTRL:   state_nxt = S_IDLE;
         S_SNAP_W: state_nxt = S_RD_L;
         S_RD_L:   state_nxt = S_RD_H;
         S_RD_H:   state_nxt = S_CAP;
         S_CAP:    state_nxt = S_IDLE;
         S_CLR:    state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Bus is registered from the next state; period_l comes from the pending copy
   // because the working copy is loaded on the same edge.
   always_comb begin
      bus_cs   = 1'b0;
      bus_wn   = 1'b1;
      bus_addr = 3'd0;
      bus_data = 16'h0000;
      case (state_nxt)
         S_PL: begin
            bus_cs = 1'b1; bus_wn = 1'b0; bus_addr = A_PER_L; bus_data = pend_period[15:0];
         end
         S_PH: begin
            bus_cs = 1'b1; bus_wn = 1'b0; bus_addr = A_PER_H; bus_data = work_period[31:16];
         end
         S_CTRL: begin
            bus_cs = 1'b1; bus_wn = 1'b0; bus_addr = A_CTRL;
            bus_data = {12'h000, 1'b0, 1'b1, work_cont, work_ito};
         end
         S_SNAP_W: begin
            bus_cs = 1'b1; bus_wn = 1'b0; bus_addr = A_SNAP_L;
         end
         S_RD_L: begin
            bus_cs = 1'b1; bus_addr = A_SNAP_L;
         end
         S_RD_H: begin
            bus_cs = 1'b1; bus_addr = A_SNAP_H;
         end
         S_CLR: begin
            bus_cs = 1'b1; bus_wn = 1'b0; bus_addr = A_STATUS;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= S_IDLE;
         start_pend    <= 1'b0;
         snap_pend     <= 1'b0;
         pend_period   <= 32'h0;
         pend_cont     <= 1'b0;
         pend_ito      <= 1'b0;
         work_period   <= 32'h0;
         work_cont     <= 1'b0;
         work_ito      <= 1'b0;
         snap_lo       <= 16'h0;
         snap_value    <= 32'h0;
         snap_valid    <= 1'b0;
         timeout_pulse <= 1'b0;
         timeout_count <= 16'h0;
         av_chipselect <= 1'b0;
         av_write_n    <= 1'b1;
         av_address    <= 3'd0;
         av_writedata  <= 16'h0;
      end else begin
         state <= state_nxt;

         // A new pulse on the edge its service starts re-arms the request.
         if (cmd_start) begin
            start_pend  <= 1'b1;
            pend_period <= cmd_period;
            pend_cont   <= cmd_continuous;
            pend_ito    <= cmd_irq_en;
         end else if (take_start) begin
            start_pend <= 1'b0;
         end
         if (snap_req)       snap_pend <= 1'b1;
         else if (take_snap) snap_pend <= 1'b0;

         if (take_start) begin
            work_period <= pend_period;
            work_cont   <= pend_cont;
            work_ito    <= pend_ito;
         end

         if (state == S_RD_H) snap_lo <= av_readdata;
         if (state == S_CAP) snap_value <= {av_readdata, snap_lo};
         snap_valid <= (state == S_CAP);

         timeout_pulse <= (state == S_CLR);
         timeout_count <= (state == S_CLR) ? sat_inc(timeout_count) : timeout_count;

         av_chipselect <= bus_cs;
         av_write_n    <= bus_wn;
         av_address    <= bus_addr;
         av_writedata  <= bus_data;
      end
   end

endmodule

// File: tb/tb_tmc_timer_master.sv
// Scoreboard bench for tmc_timer_master with a small behavioural timer slave.
module tb_tmc_timer_master;

   logic        clk;
   logic        reset_n;
   logic        cmd_start = 1'b0;
   logic [31:0] cmd_period = 32'h0;
   logic        cmd_continuous = 1'b0;
   logic        cmd_irq_en = 1'b0;
   logic        snap_req = 1'b0;
   logic        busy;
   logic        snap_valid;
   logic [31:0] snap_value;
   logic        timeout_pulse;
   logic [15:0] timeout_count;
   logic [2:0]  av_address;
   logic        av_chipselect;
   logic        av_write_n;
   logic [15:0] av_writedata;
   logic [15:0] av_readdata;
   logic        irq_in;

   tmc_timer_master dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_start(cmd_start), .cmd_period(cmd_period),
      .cmd_continuous(cmd_continuous), .cmd_irq_en(cmd_irq_en),
      .snap_req(snap_req), .busy(busy),
      .snap_valid(snap_valid), .snap_value(snap_value),
      .timeout_pulse(timeout_pulse), .timeout_count(timeout_count),
      .av_address(av_address), .av_chipselect(av_chipselect),
      .av_write_n(av_write_n), .av_writedata(av_writedata),
      .av_readdata(av_readdata), .irq_in(irq_in)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Timer slave model: snapshot latch on write to addr 4, registered reads,
   // irq level cleared by a status write.
   logic [31:0] snap_src = 32'h0;
   logic [31:0] slv_snap = 32'h0;
   logic [15:0] slv_rd = 16'h0;
   logic        irq_q = 1'b0;
   logic        irq_set = 1'b0;

   always @(posedge clk) begin
      if (av_chipselect && !av_write_n && av_address == 3'd4) slv_snap <= snap_src;
      if (av_chipselect && av_write_n)
         slv_rd <= (av_address == 3'd4) ? slv_snap[15:0] :
                   (av_address == 3'd5) ? slv_snap[31:16] : 16'h0;
      if (irq_set) irq_q <= 1'b1;
      else if (av_chipselect && !av_write_n && av_address == 3'd0) irq_q <= 1'b0;
   end
   assign av_readdata = slv_rd;
   assign irq_in      = irq_q | irq_set;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   logic [63:0] bus_q[$];
   logic [63:0] snap_q[$];
   logic [63:0] to_q[$];

   task automatic push_bus(input int c, input logic wr, input logic [2:0] a, input logic [15:0] d);
      bus_q.push_back({32'(c), 7'd0, wr, 5'd0, a, d});
   endtask

   // Monitor: every DUT bus cycle / pulse pops one expected entry (cycle + content).
   always @(negedge clk) begin
      logic [63:0] e;
      if (av_chipselect) begin
         if (bus_q.size() == 0) chk("bus_unexpected", {32'(cyc), 13'd0, av_address, av_writedata}, 64'h0);
         else begin
            e = bus_q.pop_front();
            chk("bus_cycle", {32'(cyc), 7'd0, ~av_write_n, 5'd0, av_address, av_writedata}, e);
         end
      end
      if (snap_valid) begin
         if (snap_q.size() == 0) chk("snap_unexpected", {32'(cyc), snap_value}, 64'h0);
         else begin
            e = snap_q.pop_front();
            chk("snap_value", {32'(cyc), snap_value}, e);
         end
      end
      if (timeout_pulse) begin
         if (to_q.size() == 0) chk("timeout_unexpected", {32'(cyc), 16'h0, timeout_count}, 64'h0);
         else begin
            e = to_q.pop_front();
            chk("timeout_count", {32'(cyc), 16'h0, timeout_count}, e);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_busy"}, 64'(busy), 64'h0);
      chk({tag, "_snap_valid"}, 64'(snap_valid), 64'h0);
      chk({tag, "_snap_value"}, 64'(snap_value), 64'h0);
      chk({tag, "_timeout_pulse"}, 64'(timeout_pulse), 64'h0);
      chk({tag, "_timeout_count"}, 64'(timeout_count), 64'h0);
      chk({tag, "_cs"}, 64'(av_chipselect), 64'h0);
      chk({tag, "_write_n"}, 64'(av_write_n), 64'h1);
      chk({tag, "_addr"}, 64'(av_address), 64'h0);
      chk({tag, "_wdata"}, 64'(av_writedata), 64'h0);
   endtask

   task automatic push_start(input int t, input logic [31:0] p, input logic c, input logic i);
      push_bus(t, 1'b1, 3'd2, p[15:0]);
      push_bus(t + 1, 1'b1, 3'd3, p[31:16]);
      push_bus(t + 2, 1'b1, 3'd1, {14'h0, c, i} | 16'h0004);
   endtask

   task automatic push_snap(input int t, input logic [31:0] v);
      push_bus(t, 1'b1, 3'd4, 16'h0);
      push_bus(t + 1, 1'b0, 3'd4, 16'h0);
      push_bus(t + 2, 1'b0, 3'd5, 16'h0);
      snap_q.push_back({32'(t + 4), v});
   endtask

   task automatic do_irq(input logic [15:0] exp_count);
      int t;
      t = cyc;
      push_bus(t + 1, 1'b1, 3'd0, 16'h0);
      to_q.push_back({32'(t + 2), 16'h0, exp_count});
      irq_set = 1'b1;
      tick();
      irq_set = 1'b0;
      repeat (4) tick();
   endtask

   initial begin
      int t;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("por");
      reset_n = 1'b1;
      tick();

      // Program and start
      t = cyc;
      push_start(t + 2, 32'h0EE6B27F, 1'b1, 1'b1);
      cmd_start = 1'b1; cmd_period = 32'h0EE6B27F; cmd_continuous = 1'b1; cmd_irq_en = 1'b1;
      tick();
      cmd_start = 1'b0;
      chk("start_busy_t1", 64'(busy), 64'h1);
      repeat (4) tick();
      chk("start_busy_t5", 64'(busy), 64'h0);

      // Snapshot
      snap_src = 32'h12345678;
      t = cyc;
      push_snap(t + 2, 32'h12345678);
      snap_req = 1'b1;
      tick();
      snap_req = 0;
      chk("snap_busy_t1", 64'(busy), 64'h1);
      repeat (7) tick();

      // Interrupt service
      do_irq(16'h0001);

      // All three requests together
      snap_src = 32'hDEADBEEF;
      t = cyc;
      push_bus(t + 1, 1'b1, 3'd0, 16'h0);
      to_q.push_back({32'(t + 2), 16'h0, 16'h0002});
      push_start(t + 3, 32'hA5A55A5A, 1'b1, 1'b0);
      push_snap(t + 7, 32'hDEADBEEF);
      cmd_start = 1'b1; cmd_period = 32'hA5A55A5A; cmd_continuous = 1'b1; cmd_irq_en = 1'b0;
      snap_req = 1'b1; irq_set = 1'b1;
      tick();
      cmd_start = 1'b0; snap_req = 1'b0; irq_set = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         chk($sformatf("arb_busy_t%0d", k), 64'(busy), 64'h1);
         tick();
      end
      chk("arb_busy_t11", 64'(busy), 64'h0);
      repeat (3) tick();

      // Saturation: preload the counter just below full scale
      force dut.timeout_count = 16'hFFFE;
      tick();
      release dut.timeout_count;
      tick();
      do_irq(16'hFFFF);
      do_irq(16'hFFFF);

      // Two snapshot pulses during a start sequence merge into one
      snap_src = 32'hCAFE0001;
      t = cyc;
      push_start(t + 2, 32'h00010002, 1'b0, 1'b1);
      push_snap(t + 6, 32'hCAFE0001);
      cmd_start = 1'b1; cmd_period = 32'h00010002; cmd_continuous = 1'b0; cmd_irq_en = 1'b1;
      tick();
      cmd_start = 1'b0;
      tick();
      snap_req = 1'b1;
      tick();
      snap_req = 1'b0;
      tick();
      snap_req = 1'b1;
      tick();
      snap_req = 1'b0;
      repeat (8) tick();

      // Reset during RD_H discards the partial snapshot
      snap_src = 32'h0BADF00D;
      t = cyc;
      push_bus(t + 2, 1'b1, 3'd4, 16'h0);
      push_bus(t + 3, 1'b0, 3'd4, 16'h0);
      snap_req = 1'b1;
      tick();
      snap_req = 1'b0;
      repeat (3) tick();
      reset_n = 1'b0;
      #1;
      chk_reset_vals("midrst");
      tick();
      tick();
      reset_n = 1'b1;
      repeat (8) tick();

      for (int k = 0; k < 50 && (bus_q.size() + snap_q.size() + to_q.size()) != 0; k++) tick();
      chk("bus_q_drained", 64'(bus_q.size()), 64'h0);
      chk("snap_q_drained", 64'(snap_q.size()), 64'h0);
      chk("to_q_drained", 64'(to_q.size()), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
